ysyx_23060208_axil_sram: RTL

Parametrised AXI4-Lite SRAM model: the next-generation data-side memory slave for the NPC LSU and its simulation bench. It holds an internal word array, accepts write address and write data in either order, and applies full byte strobes. Read and write latencies are configurable, and out-of-range accesses return SLVERR. Read and write channels run independently, one outstanding transaction each.

---
 rtl/ysyx_23060208_axil_pkg.sv | 11 +
 rtl/ysyx_23060208_lfsr8.sv | 11 +
 rtl/ysyx_23060208_axil_sram.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ysyx_23060208_axil_pkg.sv
// ysyx_23060208_axil_pkg: response codes, FSM state types and address-range check for the AXI4-Lite SRAM
package ysyx_23060208_axil_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [2:0] {W_IDLE, W_GOT_AW, W_GOT_W, W_WAIT, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;
  // True when base <= addr < base + size (all in bytes, widened to 64 bits by the caller).
  function automatic logic in_range(input logic [63:0] addr, input logic [63:0] base, input logic [63:0] size);
    return addr >= base && (addr - base) < size;
  endfunction
endpackage

// File: rtl/ysyx_23060208_lfsr8.sv
// ysyx_23060208_lfsr8: 8-bit Galois LFSR (taps 8,6,5,4), loaded with seed on reset, advances every cycle
// Ports: clk, rst (sync, active-high), seed[7:0] reset value, out[7:0] current state.
module ysyx_23060208_lfsr8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seed,
  output logic [7:0] out
);
  always_ff @(posedge clk)
    out <= rst ? seed : {1'b0, out[7:1]} ^ (out[0] ? 8'hB8 : 8'h00);
endmodule

// File: rtl/ysyx_23060208_axil_sram.sv
// ysyx_23060208_axil_sram: AXI4-Lite SRAM slave with configurable read/write latency and SLVERR on out-of-range access
// Ports: clk, rst (sync, active-high); AW channel awaddr/awvalid/awready; W channel wdata/wstrb/wvalid/wready;
// B channel bresp/bvalid/bready; AR channel araddr/arvalid/arready; R channel rdata/rresp/rvalid/rready.
// Define YSYX_23060208_SRAM_RAND_DELAY_EN to add 0-3 pseudo-random extra wait cycles per transaction.
module ysyx_23060208_axil_sram
  import ysyx_23060208_axil_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    R_LAT      = 1,
  parameter int                    W_LAT      = 1,
  parameter logic [7:0]            SEED       = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int SH = $clog2(NB);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [63:0] SIZE = 64'(DEPTH) * 64'(NB);
  if (SEED == 8'd0 || !(DATA_WIDTH == 32 || DATA_WIDTH == 64) || R_LAT < 1 || W_LAT < 1) begin : g_bad_cfg
    $error("ysyx_23060208_axil_sram: illegal parameter set");
  end
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  wstate_t wst;
  rstate_t rs;
  logic [ADDR_WIDTH-1:0] waddr, raddr, woff, roff;
  logic [DATA_WIDTH-1:0] wbuf;
  logic [NB-1:0] sbuf;
  logic [15:0] wcnt, rcnt;
  logic [IW-1:0] widx, ridx;
  logic [1:0] extra;
  logic aw_hs, w_hs, ar_hs, got_aw, got_w, wok, rok, commit;
`ifdef YSYX_23060208_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;
  ysyx_23060208_lfsr8 u_lfsr (.clk(clk), .rst(rst), .seed(SEED), .out(lfsr));
  assign extra = lfsr[1:0];
`else
  assign extra = 2'd0;
`endif
  assign aw_hs = awvalid && awready;
  assign w_hs = wvalid && wready;
  assign ar_hs = arvalid && arready;
  assign got_aw = aw_hs || wst == W_GOT_AW;
  assign got_w = w_hs || wst == W_GOT_W;
  assign woff = waddr - BASE_ADDR;
  assign roff = raddr - BASE_ADDR;
  assign widx = IW'(woff >> SH);
  assign ridx = IW'(roff >> SH);
  assign wok = in_range(64'(waddr), 64'(BASE_ADDR), SIZE);
  assign rok = in_range(64'(raddr), 64'(BASE_ADDR), SIZE);
  assign commit = wst == W_WAIT && wcnt == 16'd0 && wok;
  // Array is never reset; a reset during W_WAIT abandons the commit.
  always_ff @(posedge clk)
    if (!rst && commit)
      for (int i = 0; i < NB; i++)
        if (sbuf[i]) mem[widx][8*i +: 8] <= wbuf[8*i +: 8];
  // Readies are driven from the next state so they never depend combinationally on a valid.
  always_ff @(posedge clk)
    if (rst) begin
      wst <= W_IDLE;
      awready <= 1'b0;
      wready <= 1'b0;
      bvalid <= 1'b0;
      bresp <= RESP_OKAY;
    end else begin
      if (aw_hs) waddr <= awaddr;
      if (w_hs) begin
        wbuf <= wdata;
        sbuf <= wstrb;
      end
      case (wst)
        W_IDLE, W_GOT_AW, W_GOT_W: begin
          wst <= got_aw && got_w ? W_WAIT : got_aw ? W_GOT_AW : got_w ? W_GOT_W : W_IDLE;
          awready <= !got_aw;
          wready <= !got_w;
          wcnt <= 16'(W_LAT - 1) + 16'(extra);
        end
        W_WAIT:
          if (wcnt == 16'd0) begin
            wst <= W_RESP;
            bvalid <= 1'b1;
            bresp <= wok ? RESP_OKAY : RESP_SLVERR;
          end else wcnt <= wcnt - 16'd1;
        default:
          if (bready) begin
            wst <= W_IDLE;
            bvalid <= 1'b0;
            awready <= 1'b1;
            wready <= 1'b1;
          end
      endcase
    end
  always_ff @(posedge clk)
    if (rst) begin
      rs <= R_IDLE;
      arready <= 1'b0;
      rvalid <= 1'b0;
      rresp <= RESP_OKAY;
      rdata <= '0;
    end else
      case (rs)
        R_IDLE: begin
          arready <= !ar_hs;
          if (ar_hs) begin
            raddr <= araddr;
            rcnt <= 16'(R_LAT - 1) + 16'(extra);
            rs <= R_WAIT;
          end
        end
        R_WAIT:
          if (rcnt == 16'd0) begin
            rs <= R_RESP;
            rvalid <= 1'b1;
            rdata <= rok ? mem[ridx] : '0;
            rresp <= rok ? RESP_OKAY : RESP_SLVERR;
          end else rcnt <= rcnt - 16'd1;
        default:
          if (rready) begin
            rs <= R_IDLE;
            rvalid <= 1'b0;
            arready <= 1'b1;
          end
      endcase
endmodule
